// File: rtl/imem_pipelined.sv
// imem_pipelined: word-addressed instruction memory for the MIPS fetch stage.
// Latency: READ_LAT cycles from an accepted fetch_req to inst_valid (1..4).
// Backpressure: stall freezes every read stage; a fetch_req seen while stalled is dropped.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   fetch_req, fetch_addr    fetch request for a byte address (PC)
//   stall                    holds the read pipeline and the outputs
//   inst, inst_valid,        fetched word, its qualifier, the byte address that
//   inst_pc, fault           produced it, and the out-of-range/misaligned flag
//   load_we, load_addr,      program-load write port (word index), accepted
//   load_data                regardless of stall
//
// Build option: define IMEM_ALIGN_CHECK_EN to make fetches with fetch_addr[1:0] != 0
// fault. Without it the two low address bits are ignored.

module imem_pipelined #(
    parameter int                  WORD_W   = 32,
    parameter int                  DEPTH    = 1024,
    parameter int                  READ_LAT = 1,
    parameter logic [WORD_W-1:0]   NOP_WORD = {WORD_W{1'b0}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_req,
    input  logic [31:0]               fetch_addr,
    input  logic                      stall,
    output logic [WORD_W-1:0]         inst,
    output logic                      inst_valid,
    output logic [31:0]               inst_pc,
    output logic                      fault,
    input  logic                      load_we,
    input  logic [$clog2(DEPTH)-1:0]  load_addr,
    input  logic [WORD_W-1:0]         load_data
);

    localparam int AW = $clog2(DEPTH);

    // Elaboration-time guards on the parameter space.
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("imem_pipelined: READ_LAT must be in 1..4");
    end
    if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("imem_pipelined: DEPTH must be a power of two, at least 4");
    end

    // Instruction storage. Deliberately not reset: contents survive rst.
    logic [WORD_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Fetch address decode
    // ------------------------------------------------------------------
    logic [AW-1:0] word_idx;
    logic          out_of_range;
    logic          misaligned;
    logic          fetch_fault;

    assign word_idx = fetch_addr[2 +: AW];

    // Full 32-bit compare on the word number so addresses near 2^32 can never
    // alias back into the array through truncation.
    assign out_of_range = ({2'b00, fetch_addr[31:2]} >= 32'(DEPTH));

`ifdef IMEM_ALIGN_CHECK_EN
    assign misaligned = |fetch_addr[1:0];
`else
    // Low byte-offset bits are intentionally ignored in this build.
    logic unused_low_bits;
    assign unused_low_bits = ^fetch_addr[1:0];
    assign misaligned      = 1'b0;
`endif

    assign fetch_fault = out_of_range | misaligned;

    // ------------------------------------------------------------------
    // Program-load port
    // ------------------------------------------------------------------
    // A write coinciding with reset is dropped so an aborted load leaves the
    // word in its pre-edge state.
    always_ff @(posedge clk) begin
        if (load_we && !rst) begin
            mem[load_addr] <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    // Stage 0 captures the array read; later stages are plain delay
    // registers. Valid bits shift every non-stalled cycle, but a stage's
    // payload only loads when a valid entry arrives, so the outputs keep
    // their last meaningful values while inst_valid is low.
    logic [READ_LAT-1:0] s_valid;
    logic [READ_LAT-1:0] s_fault;
    logic [31:0]         s_pc   [READ_LAT];
    logic [WORD_W-1:0]   s_data [READ_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= '0;
            s_fault <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                s_pc[i]   <= '0;
                s_data[i] <= NOP_WORD;
            end
        end else if (!stall) begin
            s_valid[0] <= fetch_req;
            if (fetch_req) begin
                s_pc[0]    <= fetch_addr;
                s_fault[0] <= fetch_fault;
                // Faulting fetches never touch the array. The read uses the
                // pre-edge contents, giving read-before-write against load.
                if (fetch_fault) begin
                    s_data[0] <= NOP_WORD;
                end else begin
                    s_data[0] <= mem[word_idx];
                end
            end
            for (int i = 1; i < READ_LAT; i++) begin
                s_valid[i] <= s_valid[i-1];
                if (s_valid[i-1]) begin
                    s_pc[i]    <= s_pc[i-1];
                    s_fault[i] <= s_fault[i-1];
                    s_data[i]  <= s_data[i-1];
                end
            end
        end
    end

    // The last stage drives the fetch-stage outputs directly.
    assign inst       = s_data[READ_LAT-1];
    assign inst_valid = s_valid[READ_LAT-1];
    assign inst_pc    = s_pc[READ_LAT-1];
    assign fault      = s_fault[READ_LAT-1];

endmodule

// File: doc/imem_pipelined.md
# imem_pipelined

Parametrised, synchronous instruction memory for the MIPS fetch stage. It replaces a combinational, byte-indexed lookup with a word-addressed array, a configurable-latency read pipeline and a program-load write port. It flags out-of-range fetches and, optionally, misaligned fetches. It sits between the PC register and the IF/ID pipeline register and supports stall-driven freezing.

## Interface
Parameters:
- `WORD_W`, 32: instruction width in bits.
- `DEPTH`, 1024: number of instruction words; power of two, at least 4.
- `READ_LAT`, 1: fetch-to-data latency in cycles; legal range 1..4.
- `NOP_WORD`, 32'h00000000: word returned on a fault (MIPS `sll $0,$0,0`).

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `fetch_req`, in, 1: fetch request for `fetch_addr`.
- `fetch_addr`, in, 32: byte address (PC).
- `stall`, in, 1: freezes the read pipeline and outputs.
- `inst`, out, WORD_W: fetched instruction.
- `inst_valid`, out, 1: `inst`, `inst_pc` and `fault` are meaningful.
- `inst_pc`, out, 32: byte address that produced `inst`.
- `fault`, out, 1: the fetch was out of range (or misaligned, see Configuration).
- `load_we`, in, 1: program-load write enable.
- `load_addr`, in, clog2(DEPTH): word index for the load.
- `load_data`, in, WORD_W: word to write.

## Operation
- Word index is `fetch_addr[2 +: clog2(DEPTH)]`.
- A fetch is out of range if `fetch_addr >> 2` ≥ DEPTH. Such a fetch returns `inst` = NOP_WORD and `fault` = 1, and the array is not read.
- Read pipeline: READ_LAT stages. Each stage holds `{valid, pc, fault, data}`.
  - Stage 1 captures the array read.
  - Stages 2..READ_LAT are plain delay registers.
  - The last stage drives the outputs.
- When `stall` = 0:
  - Stage 1 loads `valid <= fetch_req`.
  - Every other stage shifts.
  - Throughput is one fetch per cycle.
- When `stall` = 1:
  - All stages hold.
  - `fetch_req` is ignored and dropped. The PC owner must re-present the request after the stall.
- Load port:
  - `load_we` = 1 writes `load_data` to `array[load_addr]` on the edge.
  - Loads are accepted regardless of `stall`.
- Read-during-write to the same word in the same cycle returns the OLD contents. The new word is visible to fetches issued on the next cycle or later.
- When `inst_valid` = 0, `inst`, `inst_pc` and `fault` hold their last values. They are not zeroed.
- Reset:
  - `inst_valid` = 0, `inst` = NOP_WORD, `inst_pc` = 0, `fault` = 0.
  - Every pipeline-stage valid bit clears immediately, including mid-flight fetches. In-flight requests are lost and never reported.
  - Array contents are NOT reset. Reset mid-load leaves the array in its pre-edge state for the aborted write.
- Array contents are undefined until loaded. A bench must load before fetching.

## Timing
- Fetch presented with `stall` = 0 before edge N: `inst_valid` = 1 after edge N+READ_LAT−1. For example, with READ_LAT = 1 data appears after the capturing edge.
- With k stall cycles inside the window, latency is READ_LAT + k.
- Back-to-back requests on consecutive non-stalled cycles produce back-to-back `inst_valid` pulses in order.
- Reset is asynchronous on assertion. Release is synchronised externally. The first accepted fetch is on the first edge with `rst` low.
- A fetch where `load_we` writes to the same index on the same edge follows the read-before-write rule.
- Edge cases:
  - Highest word DEPTH−1 is in range.
  - Byte address `DEPTH*4` is the first out-of-range address.
  - Addresses at or above 2^32−4 are out of range, with no wrap-around into the array.

## Configuration
- `IMEM_ALIGN_CHECK_EN`:
  - Defined: a fetch with `fetch_addr[1:0]` ≠ 0 is a fault (NOP_WORD, `fault` = 1). Out-of-range and misaligned faults are ORed.
  - Undefined: `fetch_addr[1:0]` is ignored, the word at the truncated index is returned, and only the out-of-range check drives `fault`.

## Test plan
- Load words 0..8 with the nine-instruction add/lw/sub/beq/sw sequence (word 0 = 32'h00004020, word 8 = 32'hAC080000). Fetch byte addresses 0,4,…,32 back-to-back with READ_LAT = 2. Required: nine consecutive `inst_valid` pulses, the first after edge 2, with matching `inst_pc`, `fault` = 0 throughout.
- Fetch byte address 32'h00001000 with DEPTH = 1024. Required: `inst` = 32'h00000000, `fault` = 1, `inst_valid` = 1 after READ_LAT. Fetching 32'h00000FFC must return the loaded word with `fault` = 0.
- In the same cycle, load word 3 with 32'hDEADBEEF and fetch address 12 (old value 32'h012A4020). Required: 32'h012A4020. A refetch on the next cycle returns 32'hDEADBEEF.
- Issue a fetch, assert `stall` for 3 cycles mid-pipeline, and present `fetch_req` during the stall. Required: data emerges at READ_LAT + 3, outputs hold during the stall, and the stalled request produces no pulse.
- With READ_LAT = 3, assert `rst` while two fetches are in flight. Required: `inst_valid` = 0 immediately and no later pulse. Array contents remain readable after release.
- Fetch address 6:
  - With `IMEM_ALIGN_CHECK_EN`: `fault` = 1 and NOP_WORD.
  - Without it: the word at index 1 with `fault` = 0.
